cache_miss_controller: RTL and testbench

//  Sequences the direct-mapped data cache between the CPU load/store port and main memory.

---
 rtl/cache_miss_controller.sv | 190 +++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_controller.sv
// Cache miss controller: sequences a direct-mapped, write-through,
// no-write-allocate data cache between the CPU load/store port and memory.
// Loads probe the cache and refill the line from memory on a miss. Stores
// update the cache only on a hit and are always written through to memory.
// Handshakes: cpu_req_i is a level request that must stay high while
// cpu_stall_o=1; cpu_done_o pulses for one cycle when the access completes.
// mem_req_o is held until mem_ack_i is seen, or until the wait limit expires.
module cache_miss_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  cpu_done_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    output logic [DATA_WIDTH-1:0] cache_wdata_o,
    output logic                  cache_we_o,
    input  logic                  cache_hit_i,
    input  logic [DATA_WIDTH-1:0] cache_rdata_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  hit_count_o,
    output logic [CNT_WIDTH-1:0]  miss_count_o,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam int WW = $clog2(WAIT_LIMIT + 1);
    // Value of the wait counter in the last cycle a memory access may wait.
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [WW-1:0]         r_wait;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic                  r_done;
    logic                  w_cache_we;
    logic                  w_stall;
    logic                  w_timeout;

    // Cache write strobe: store hit during the probe, or the refill cycle.
    // The probe result is only known during LOOKUP, so this is a decode.
    always_comb begin
        w_cache_we = ((r_state == S_LOOKUP) && r_we && cache_hit_i) ||
                     (r_state == S_FILL);
    end

    // Stall the CPU from the accepting IDLE cycle up to (not including) RESP.
    always_comb begin
        w_stall   = ((r_state == S_IDLE) && cpu_req_i) ||
                    (r_state == S_LOOKUP) || (r_state == S_MEM_RD) ||
                    (r_state == S_FILL)   || (r_state == S_MEM_WR);
        w_timeout = (r_wait == WAIT_LAST) && !mem_ack_i;
    end

    // Main sequencer: state, request latches, registered strobes and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_fill     <= '0;
            r_rdata    <= '0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        r_addr  <= cpu_addr_i;
                        r_wdata <= cpu_wdata_i;
                        r_we    <= cpu_we_i;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit_i) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                    r_wait <= '0;
                    if (r_we) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_state   <= S_MEM_WR;
                    end else if (cache_hit_i) begin
                        r_rdata <= cache_rdata_i;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    // An ack arriving on the last allowed cycle still wins.
                    if (mem_ack_i) begin
                        r_rdata   <= mem_rdata_i;
                        r_fill    <= mem_rdata_i;
                        r_mem_req <= 1'b0;
                        r_state   <= S_FILL;
                    end else if (w_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_FILL: begin
                    r_done  <= 1'b1;
                    r_state <= S_RESP;
                end
                S_MEM_WR: begin
                    if (mem_ack_i || w_timeout) begin
                        if (!mem_ack_i) r_err <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata_o   = r_rdata;
    assign cpu_stall_o   = w_stall;
    assign cpu_done_o    = r_done;
    assign cache_addr_o  = r_addr;
    assign cache_wdata_o = (r_state == S_FILL) ? r_fill : r_wdata;
    assign cache_we_o    = w_cache_we;
    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_mem_we;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign err_o         = r_err;
    assign hit_count_o   = r_hit_cnt;
    assign miss_count_o  = r_miss_cnt;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: a cache array and a memory array act as
// the environment, and a transaction-level model predicts, per cycle, the
// stall/done/request/strobe outputs from the access type and ack delay.
module tb_cache_miss_controller;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int LIMIT   = 64;

  logic              clk;
  logic              rst;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;
  logic              cpu_done_o;
  logic [31:0]       cache_addr_o;
  logic [31:0]       cache_wdata_o;
  logic              cache_we_o;
  logic              cache_hit_i;
  logic [31:0]       cache_rdata_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;
  logic              err_o;
  logic [CNT_W-1:0]  hit_count_o;
  logic [CNT_W-1:0]  miss_count_o;
  logic [2:0]        dbg_state_o;

  cache_miss_controller #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_LIMIT(LIMIT), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o), .cpu_done_o(cpu_done_o),
    .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
    .cache_we_o(cache_we_o), .cache_hit_i(cache_hit_i),
    .cache_rdata_i(cache_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] cache_m [logic [31:0]];
  logic [31:0] mem_m   [logic [31:0]];
  logic [31:0] exp_q[$];

  // transaction model
  bit          active = 1'b0;
  int          t0, done_c, m_cyc, ack_n;
  bit          m_we, m_hit, m_timeout, m_fill;
  logic [31:0] m_addr, m_wdata, m_rdata_exp;
  logic [31:0] last_rdata = 32'h0;
  bit          exp_err = 1'b0;
  int          exp_hits = 0;
  int          exp_misses = 0;
  int          ack_delay = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- environment: cache and memory responders ----------------
  initial begin
    mem_ack_i     = 1'b0;
    mem_rdata_i   = 32'hBAD0BAD0;
    cache_hit_i   = 1'b0;
    cache_rdata_i = 32'h0;
    begin
      int req_cnt;
      req_cnt = 0;
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        cache_hit_i   = cache_m.exists(cache_addr_o);
        cache_rdata_i = cache_hit_i ? cache_m[cache_addr_o] : 32'h0;
        if (mem_req_o && !rst) begin
          req_cnt++;
          if (ack_delay != 0 && req_cnt == ack_delay) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) mem_m[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o] : 32'h0;
          end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0BAD0;
          end
        end else begin
          req_cnt     = 0;
          mem_ack_i   = 1'b0;
          mem_rdata_i = 32'hBAD0BAD0;
        end
      end
    end
  end

  // cache array absorbs every write strobe
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cache_we_o) cache_m[cache_addr_o] = cache_wdata_o;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  initial begin
    int c;
    bit e_done, e_stall, e_mreq, e_cwe, e_err;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (active) begin
        c       = cyc - t0;
        e_done  = (c == done_c);
        e_stall = (c < done_c);
        e_mreq  = (m_cyc > 0) && (c >= 2) && (c <= 1 + m_cyc);
        e_cwe   = (m_we && m_hit && c == 1) || (m_fill && c == 2 + ack_n);
        e_err   = exp_err || (m_timeout && c >= done_c);
      end else begin
        c       = -1;
        e_done  = 1'b0;
        e_stall = 1'b0;
        e_mreq  = 1'b0;
        e_cwe   = 1'b0;
        e_err   = exp_err;
      end
      chk1("stall", cpu_stall_o, e_stall);
      chk1("done", cpu_done_o, e_done);
      chk1("mem_req", mem_req_o, e_mreq);
      chk1("cache_we", cache_we_o, e_cwe);
      chk1("err", err_o, e_err);
      if (active && c >= 1) chk32("cache_addr", cache_addr_o, m_addr);
      if (e_mreq) begin
        chk1("mem_we", mem_we_o, m_we);
        chk32("mem_addr", mem_addr_o, m_addr);
        if (m_we) chk32("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (e_cwe) chk32("cache_wdata", cache_wdata_o, m_we ? m_wdata : m_rdata_exp);
      if (e_done && !m_we) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rdata_queue at cycle %0d: got empty expected entry", cyc);
        end else begin
          last_rdata = exp_q.pop_front();
          chk32("rdata_done", cpu_rdata_o, last_rdata);
        end
      end
      if (!active) chk32("rdata_held", cpu_rdata_o, last_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  // n = memory cycles until ack (0 = never acks)
  task automatic start_access(input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input bit hit,
                              input int n, input logic [31:0] rd);
    int mc;
    @(posedge clk);
    #2;
    t0          = cyc;
    m_we        = we;
    m_hit       = hit;
    m_addr      = addr;
    m_wdata     = wdata;
    m_rdata_exp = rd;
    ack_n       = n;
    if (!we && hit) begin
      m_cyc = 0; m_fill = 1'b0; m_timeout = 1'b0; done_c = 2;
    end else begin
      mc        = (n == 0) ? LIMIT : n;
      m_cyc     = mc;
      m_timeout = (n == 0);
      m_fill    = !we && (n != 0);
      done_c    = (we || n == 0) ? 2 + mc : 3 + n;
    end
    if (!we) exp_q.push_back(m_timeout ? 32'h0 : rd);
    if (hit) begin
      if (exp_hits < CNT_MAX) exp_hits++;
    end else begin
      if (exp_misses < CNT_MAX) exp_misses++;
    end
    ack_delay   = n;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    cpu_req_i   = 1'b1;
    active      = 1'b1;
  endtask

  task automatic finish_access();
    repeat (done_c) @(posedge clk);
    #2;
    cpu_req_i = 1'b0;
    @(posedge clk);
    #2;
    active = 1'b0;
    if (m_timeout) exp_err = 1'b1;
    chk32("hit_count", 32'(hit_count_o), 32'(exp_hits));
    chk32("miss_count", 32'(miss_count_o), 32'(exp_misses));
  endtask

  task automatic access(input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit hit,
                        input int n, input logic [31:0] rd);
    start_access(we, addr, wdata, hit, n, rd);
    finish_access();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_m[32'h40]  = 32'hDEADBEEF;
    mem_m[32'h200] = 32'hA5A5A5A5;
    #1;
    chk1("reset_mem_req", mem_req_o, 1'b0);
    chk32("reset_state", 32'(dbg_state_o), 32'd0);
    chk32("reset_rdata", cpu_rdata_o, 32'h0);
    chk32("reset_addr", cache_addr_o, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // cold load miss, ack after 3 memory cycles
    access(1'b0, 32'h40, 32'h0, 1'b0, 3, 32'hDEADBEEF);
    chk32("t1_rdata", cpu_rdata_o, 32'hDEADBEEF);
    chk32("t1_miss", 32'(miss_count_o), 32'd1);
    chk32("t1_cache_fill", cache_m.exists(32'h40) ? cache_m[32'h40] : 32'h0, 32'hDEADBEEF);

    // repeat load hits
    access(1'b0, 32'h40, 32'h0, 1'b1, 0, 32'hDEADBEEF);
    chk32("t2_hit", 32'(hit_count_o), 32'd1);

    // store hit: cache update, then write-through
    access(1'b1, 32'h40, 32'h12345678, 1'b1, 2, 32'h0);
    chk32("t3_mem", mem_m[32'h40], 32'h12345678);
    chk32("t3_cache", cache_m[32'h40], 32'h12345678);
    chk32("t3_rdata_kept", cpu_rdata_o, 32'hDEADBEEF);

    // store miss: memory only
    access(1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 1, 32'h0);
    chk1("t4_no_alloc", cache_m.exists(32'h80), 1'b0);
    chk32("t4_mem", mem_m.exists(32'h80) ? mem_m[32'h80] : 32'h0, 32'hCAFEF00D);
    chk32("t4_miss", 32'(miss_count_o), 32'd2);

    // store miss whose ack lands on the last allowed cycle: no error
    access(1'b1, 32'h300, 32'h0BADCAFE, 1'b0, LIMIT, 32'h0);
    chk1("t_ack_at_limit_err", err_o, 1'b0);
    chk32("t_ack_at_limit_mem", mem_m.exists(32'h300) ? mem_m[32'h300] : 32'h0, 32'h0BADCAFE);

    // load miss that never acks: timeout, saturated miss counter
    access(1'b0, 32'h100, 32'h0, 1'b0, 0, 32'h0);
    chk1("t5_err", err_o, 1'b1);
    chk32("t5_rdata", cpu_rdata_o, 32'h0);
    chk1("t5_no_fill", cache_m.exists(32'h100), 1'b0);
    chk32("t5_miss_sat", 32'(miss_count_o), 32'd3);

    // reset during MEM_RD
    start_access(1'b0, 32'h200, 32'h0, 1'b0, 5, 32'hA5A5A5A5);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_mem_req", mem_req_o, 1'b0);
    chk32("t6_state", 32'(dbg_state_o), 32'd0);
    chk32("t6_hits", 32'(hit_count_o), 32'd0);
    chk32("t6_misses", 32'(miss_count_o), 32'd0);
    chk1("t6_err", err_o, 1'b0);
    chk1("t6_cache_we", cache_we_o, 1'b0);
    active     = 1'b0;
    cpu_req_i  = 1'b0;
    ack_delay  = 0;
    exp_q.delete();
    exp_hits   = 0;
    exp_misses = 0;
    exp_err    = 1'b0;
    last_rdata = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk1("t6_no_fill", cache_m.exists(32'h200), 1'b0);

    // normal operation after reset
    access(1'b0, 32'h200, 32'h0, 1'b0, 2, 32'hA5A5A5A5);
    chk32("t7_rdata", cpu_rdata_o, 32'hA5A5A5A5);
    access(1'b0, 32'h40, 32'h0, 1'b1, 0, 32'h12345678);
    chk32("t8_rdata", cpu_rdata_o, 32'h12345678);
    chk32("t8_hit", 32'(hit_count_o), 32'd1);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog at cycle %0d: got no end expected end of sequence", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
